// File: rtl/mult_datapath.sv
// Shift-add multiplier datapath: A, B, S, P registers driven by one-hot strobes.
// Define MULT_SEQ_CHECK_EN to build the strobe protocol checker behind seq_err.
module mult_datapath #(
    parameter int unsigned W = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           clr,
    input  logic           load_ab,
    input  logic           en_add,
    input  logic           load_p,
    input  logic           shf_p,
    input  logic           shf_b,
    input  logic [W-1:0]   a_in,
    input  logic [W-1:0]   b_in,
    output logic [2*W-1:0] product,
    output logic           done,
    output logic           seq_err
);

    localparam int unsigned CW = $clog2(W + 1);

    typedef enum logic [2:0] {
        OP_NONE,
        OP_CLR,
        OP_LDAB,
        OP_ADD,
        OP_LDP,
        OP_SHP,
        OP_SHB
    } op_e;

    op_e           op;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic [W:0]    s_q;
    logic [2*W:0]  p_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_inc;
    logic          last_shift;
    logic [W-1:0]  addend;

    // Only the highest-priority strobe of a cycle executes.
    always_comb begin
        op = OP_NONE;
        if (clr)          op = OP_CLR;
        else if (load_ab) op = OP_LDAB;
        else if (en_add)  op = OP_ADD;
        else if (load_p)  op = OP_LDP;
        else if (shf_p)   op = OP_SHP;
        else if (shf_b)   op = OP_SHB;
    end

    assign cnt_inc    = cnt_q + CW'(1);
    assign last_shift = (cnt_inc == CW'(W));
    assign addend     = b_q[0] ? a_q : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q   <= '0;
            b_q   <= '0;
            s_q   <= '0;
            p_q   <= '0;
            cnt_q <= '0;
            done  <= 1'b0;
        end else begin
            case (op)
                OP_CLR: begin
                    a_q   <= '0;
                    b_q   <= '0;
                    s_q   <= '0;
                    p_q   <= '0;
                    cnt_q <= '0;
                    done  <= 1'b0;
                end
                OP_LDAB: begin
                    a_q   <= a_in;
                    b_q   <= b_in;
                    p_q   <= '0;
                    cnt_q <= '0;
                    done  <= 1'b0;
                end
                OP_ADD: s_q <= {1'b0, p_q[2*W-1:W]} + {1'b0, addend};
                OP_LDP: p_q[2*W:W] <= s_q;
                OP_SHP: begin
                    p_q   <= p_q >> 1;
                    cnt_q <= cnt_inc;
                    if (last_shift) done <= 1'b1;
                end
                OP_SHB: b_q <= b_q >> 1;
                default: ;
            endcase
        end
    end

    assign product = p_q[2*W-1:0];

`ifdef MULT_SEQ_CHECK_EN
    typedef enum logic [2:0] {
        C_IDLE,
        C_CLR,
        C_ADD,
        C_LDP,
        C_SHP,
        C_SHB,
        C_DONE
    } chk_e;

    chk_e chk_q;
    chk_e chk_d;
    logic err_q;
    logic err_d;
    logic legal;
    logic multi;

    assign multi = ($countones({clr, load_ab, en_add, load_p, shf_p, shf_b}) > 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chk_q <= C_IDLE;
            err_q <= 1'b0;
        end else begin
            chk_q <= chk_d;
            err_q <= err_d;
        end
    end

    // The executed strobe advances the checker; a simultaneous extra strobe
    // still flags an error even when that executed strobe was the expected one.
    always_comb begin
        chk_d = chk_q;
        err_d = err_q;
        legal = 1'b0;
        if (op == OP_CLR) begin
            chk_d = C_CLR;
            err_d = 1'b0;
        end else if (op != OP_NONE) begin
            case (chk_q)
                C_CLR: if (op == OP_LDAB) begin legal = 1'b1; chk_d = C_ADD; end
                C_ADD: if (op == OP_ADD)  begin legal = 1'b1; chk_d = C_LDP; end
                C_LDP: if (op == OP_LDP)  begin legal = 1'b1; chk_d = C_SHP; end
                C_SHP: if (op == OP_SHP)  begin
                    legal = 1'b1;
                    chk_d = last_shift ? C_DONE : C_SHB;
                end
                C_SHB: if (op == OP_SHB)  begin legal = 1'b1; chk_d = C_ADD; end
                default: legal = 1'b0;
            endcase
            if (!legal || multi) err_d = 1'b1;
        end
    end

    assign seq_err = err_q;
`else
    assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_mult_datapath.sv
// Randomised self-checking bench for mult_datapath with an arithmetic reference model.
// Honours MULT_SEQ_CHECK_EN the same way as the design.
module tb_mult_datapath;

    localparam int W  = 4;
    localparam int CW = $clog2(W + 1);
`ifdef MULT_SEQ_CHECK_EN
    localparam int CHK = 1;
`else
    localparam int CHK = 0;
`endif

    logic           clk = 1'b0;
    logic           reset;
    logic           clr, load_ab, en_add, load_p, shf_p, shf_b;
    logic [W-1:0]   a_in, b_in;
    logic [2*W-1:0] product;
    logic           done;
    logic           seq_err;

    int checks = 0;
    int errors = 0;

    mult_datapath #(.W(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .clr     (clr),
        .load_ab (load_ab),
        .en_add  (en_add),
        .load_p  (load_p),
        .shf_p   (shf_p),
        .shf_b   (shf_b),
        .a_in    (a_in),
        .b_in    (b_in),
        .product (product),
        .done    (done),
        .seq_err (seq_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model. Strobe bit numbers: 5 clr, 4 load_ab, 3 en_add, 2 load_p, 1 shf_p, 0 shf_b.
    // mexp is the only non-clr strobe the protocol accepts next (-1: none).
    int mA, mB, mS, mP, mcnt, mdone, merr, mexp;
    logic [5:0] mmask;
    int k, n;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mA = 0; mB = 0; mS = 0; mP = 0; mcnt = 0; mdone = 0; merr = 0; mexp = -1;
        end else begin
            mmask = {clr, load_ab, en_add, load_p, shf_p, shf_b};
            n = $countones(mmask);
            k = -1;
            for (int i = 0; i < 6; i++) if (mmask[i]) k = i;
            if (CHK != 0) begin
                if (k == 5) begin
                    merr = 0;
                    mexp = 4;
                end else if (k >= 0) begin
                    if (n > 1) merr = 1;
                    if (k != mexp) merr = 1;
                    else case (k)
                        4: mexp = 3;
                        3: mexp = 2;
                        2: mexp = 1;
                        1: mexp = (((mcnt + 1) % (1 << CW)) == W) ? -1 : 0;
                        default: mexp = 3;
                    endcase
                end
            end
            case (k)
                5: begin mA = 0; mB = 0; mS = 0; mP = 0; mcnt = 0; mdone = 0; end
                4: begin mA = a_in; mB = b_in; mP = 0; mcnt = 0; mdone = 0; end
                3: mS = ((mP >> W) % (1 << W)) + ((mB % 2 == 1) ? mA : 0);
                2: mP = (mP % (1 << W)) + mS * (1 << W);
                1: begin
                    mP = mP / 2;
                    mcnt = (mcnt + 1) % (1 << CW);
                    if (mcnt == W) mdone = 1;
                end
                0: mB = mB / 2;
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        check("product", int'(product), mP % (1 << (2 * W)));
        check("done", int'(done), mdone);
        check("seq_err", int'(seq_err), merr);
    end

    task automatic strobe(input logic [5:0] m);
        {clr, load_ab, en_add, load_p, shf_p, shf_b} = m;
        @(posedge clk);
        #1;
        {clr, load_ab, en_add, load_p, shf_p, shf_b} = '0;
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic gap(input int maxgap);
        if (maxgap > 0) begin
            int g = $urandom_range(0, maxgap);
            if (g > 0) idle(g);
        end
    endtask

    task automatic run_mult(input int a, input int b, input int maxgap);
        strobe(6'b100000);
        check("done_after_clr", int'(done), 0);
        gap(maxgap);
        a_in = W'(a);
        b_in = W'(b);
        strobe(6'b010000);
        check("done_after_load", int'(done), 0);
        for (int i = 0; i < W; i++) begin
            gap(maxgap); strobe(6'b001000);
            gap(maxgap); strobe(6'b000100);
            gap(maxgap); strobe(6'b000010);
            if (i < W - 1) begin
                check("done_early", int'(done), 0);
                gap(maxgap); strobe(6'b000001);
            end
        end
        check("result", int'(product), a * b);
        check("result_done", int'(done), 1);
        check("result_seq_err", int'(seq_err), 0);
    endtask

    initial begin
        reset = 1'b1;
        {clr, load_ab, en_add, load_p, shf_p, shf_b} = '0;
        a_in = '0;
        b_in = '0;
        #1;
        check("rst_product", int'(product), 0);
        check("rst_done", int'(done), 0);
        check("rst_seq_err", int'(seq_err), 0);
        #21 reset = 1'b0;
        @(posedge clk); #1;

        run_mult(13, 11, 0);
        idle(2);
        check("done_held", int'(done), 1);
        run_mult(15, 15, 0);
        run_mult(0, 9, 0);
        run_mult(7, 6, 3);

        // Reset in the middle of the second iteration.
        strobe(6'b100000);
        a_in = 4'd13; b_in = 4'd11;
        strobe(6'b010000);
        strobe(6'b001000); strobe(6'b000100); strobe(6'b000010); strobe(6'b000001);
        strobe(6'b001000); strobe(6'b000100);
        #2 reset = 1'b1;
        #1;
        check("abort_product", int'(product), 0);
        check("abort_done", int'(done), 0);
        check("abort_seq_err", int'(seq_err), 0);
        @(posedge clk); #2 reset = 1'b0;
        @(posedge clk); #1;
        run_mult(9, 5, 0);

        // Out-of-order shift straight after clr.
        strobe(6'b100000);
        strobe(6'b000010);
        check("ooo_err", int'(seq_err), CHK);
        idle(3);
        check("ooo_err_sticky", int'(seq_err), CHK);
        strobe(6'b100000);
        check("ooo_err_cleared", int'(seq_err), 0);

        // Two strobes in C_ADD, then clr with load_ab.
        a_in = 4'd3; b_in = 4'd5;
        strobe(6'b010000);
        strobe(6'b001001);
        check("multi_err", int'(seq_err), CHK);
        strobe(6'b000100);
        check("multi_add_only", int'(product), 48);
        strobe(6'b110000);
        check("clr_ld_err", int'(seq_err), 0);
        check("clr_ld_product", int'(product), 0);
        check("clr_ld_done", int'(done), 0);

        for (int t = 0; t < 15; t++)
            run_mult(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), t % 3);

        // Unconstrained strobe traffic against the model.
        for (int t = 0; t < 400; t++) begin
            int r = $urandom_range(0, 9);
            logic [5:0] m;
            a_in = W'($urandom);
            b_in = W'($urandom);
            if (r < 3)      m = '0;
            else if (r < 8) m = 6'(1 << $urandom_range(0, 4));
            else            m = 6'($urandom_range(0, 63));
            strobe(m);
        end
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_datapath.md
# mult_datapath

Datapath and strobe checker for the shift-add multiplier. It consumes the one-hot control strobes from the multiplier sequencing FSM (`clr`, `load_ab`, `en_add`, `load_p`, `shf_p`, `shf_b`) and owns the A, B, sum and partial-product registers. It delivers the unsigned 2W-bit product with a `done` flag. An optional sequence checker raises a sticky error when strobes arrive out of protocol order.

## Interface
- `W`, default 4: operand width in bits.
- `clk` input, 1 bit: clock, rising edge.
- `reset` input, 1 bit: asynchronous, active-high reset.
- `clr` input, 1 bit: clear strobe.
- `load_ab` input, 1 bit: load operands strobe.
- `en_add` input, 1 bit: compute conditional add strobe.
- `load_p` input, 1 bit: write sum into the upper half of P strobe.
- `shf_p` input, 1 bit: shift P right strobe.
- `shf_b` input, 1 bit: shift B right strobe.
- `a_in` input, W bits: multiplicand, sampled on `load_ab`.
- `b_in` input, W bits: multiplier, sampled on `load_ab`.
- `product` output, 2W bits: equals P[2W-1:0], registered.
- `done` output, 1 bit: product valid.
- `seq_err` output, 1 bit: sticky protocol error.

## Operation
- Registers:
  - A[W-1:0]
  - B[W-1:0]
  - S[W:0], the sum with carry
  - P[2W:0], the partial product with a carry guard bit
  - cnt, the shift count, `$clog2(W+1)` bits
- Each strobe acts on the rising edge where it is sampled high. Idle cycles between strobes are legal and hold all state.
- When several strobes are high in one cycle, only the highest-priority one executes. Priority order: `clr` > `load_ab` > `en_add` > `load_p` > `shf_p` > `shf_b`.
- `clr`: A, B, S, P and cnt go to 0; `done` goes to 0; `seq_err` goes to 0.
- `load_ab`: A ← `a_in`, B ← `b_in`, P ← 0, cnt ← 0, `done` ← 0.
- `en_add`: S ← P[2W-1:W] + (B[0] ? A : 0), computed as a (W+1)-bit unsigned sum.
- `load_p`: P[2W:W] ← S; P[W-1:0] is unchanged.
- `shf_p`: P ← P >> 1 (logical) and cnt ← cnt+1. If cnt+1 == W, `done` ← 1.
- `shf_b`: B ← B >> 1 (logical).
- `done` is held until the next `clr` or `load_ab`. Strobes arriving after `done` still execute; they corrupt the product and flag `seq_err`.
- Sequence checker states: C_IDLE, C_CLR, C_ADD, C_LDP, C_SHP, C_SHB, C_DONE.
- Checker transitions:
  - Any state, on `clr` → C_CLR.
  - C_CLR, on `load_ab` → C_ADD.
  - C_ADD, on `en_add` → C_LDP.
  - C_LDP, on `load_p` → C_SHP.
  - C_SHP, on `shf_p` → C_DONE if the new cnt == W, otherwise C_SHB.
  - C_SHB, on `shf_b` → C_ADD.
- Checker errors:
  - Any other strobe sets `seq_err` (sticky) and leaves the checker state unchanged.
  - More than one strobe high in a cycle sets `seq_err`, unless `clr` is among them.
  - Any strobe other than `clr` in C_IDLE or C_DONE sets `seq_err`.

## Timing
- Reset values: A, B, S, P and cnt are 0; `product` = 0, `done` = 0, `seq_err` = 0; checker in C_IDLE.
- Reset asserted mid-operation aborts immediately. Outputs return to reset values asynchronously.
- Latency: `done` and the final `product` appear one cycle after the edge that samples the W-th `shf_p`.
- With the sequencing FSM running back-to-back strobes, `done` rises in the 17th cycle after `reset` deasserts (W=4).
- `seq_err` asserts in the cycle after the offending edge.
- `clr` and `load_ab` drop `done` in the cycle after their edge.
- No combinational path exists from the strobes to any output.

## Configuration
- `MULT_SEQ_CHECK_EN` defined: the sequence checker is built and `seq_err` behaves as specified above.
- `MULT_SEQ_CHECK_EN` undefined: the checker is not built and `seq_err` is tied to 0. The datapath behaviour, including strobe priority, is unchanged.

## Test plan
- W=4, a=13, b=11, legal back-to-back sequence → `product`=143, `done`=1 one cycle after the 4th `shf_p`, `seq_err`=0.
- a=15, b=15 → `product`=225, which exercises the carry into P[2W]. Then a=0, b=9 → `product`=0. `done` drops after each new `clr`/`load_ab`.
- Legal sequence with 0–3 random idle cycles between strobes, a=7, b=6 → `product`=42, `seq_err`=0.
- Assert `reset` after the 2nd `load_p` → all outputs 0 immediately. A fresh sequence with a=9, b=5 then yields 45.
- `shf_p` before `load_ab` after `clr` → `seq_err`=1 held. The next `clr` clears it to 0. With `MULT_SEQ_CHECK_EN` undefined, `seq_err` stays 0 throughout.
- `en_add` and `shf_b` high together in C_ADD → only the add executes and `seq_err`=1. `clr` and `load_ab` high together → clear only, no error.
